// File: rtl/alu_operand_sequencer.sv
// Operand/opcode collector for the registered ALU stage: one switch value per button press,
// a single issue pulse, a fixed-latency wait, then result/flags capture for display.
module alu_operand_sequencer #(
  parameter int unsigned N   = 5,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn,
  input  logic         clr,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [3:0]   sel,
  output logic         issue,
  output logic         busy,
  input  logic [N-1:0] res_in,
  input  logic [3:0]   flags_in,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         done,
  output logic [2:0]   state_dbg
);

  localparam int unsigned CW = $clog2(LAT) + 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t        r_state, w_state_d;
  logic          r_sync1, r_sync2, r_prev;
  logic [N-1:0]  r_a, r_b, r_result;
  logic [3:0]    r_sel, r_flags;
  logic [CW-1:0] r_cnt;
  logic          r_issue, r_cap, r_done;
  logic          w_press, w_last;

  assign w_press = r_sync2 & ~r_prev;
  assign w_last  = (r_cnt == CW'(LAT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_A;
    else      r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_A:     if (w_press) w_state_d = S_B;
      S_B:     if (w_press) w_state_d = S_OP;
      S_OP:    if (w_press) w_state_d = S_WAIT;
      S_WAIT:  if (w_last)  w_state_d = S_SHOW;
      S_SHOW:  if (w_press) w_state_d = S_A;
      default: w_state_d = S_A;
    endcase
    if (clr) w_state_d = S_A;
  end

  // done trails the capture edge by one cycle so result/flags are already stable while it is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_issue  <= 1'b0;
      r_cap    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      r_cap   <= 1'b0;
      r_done  <= r_cap;
      if (clr) begin
        r_a    <= '0;
        r_b    <= '0;
        r_sel  <= '0;
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else begin
        unique case (r_state)
          S_A: if (w_press) r_a <= sw;
          S_B: if (w_press) r_b <= sw;
          S_OP: begin
            if (w_press) begin
              r_sel   <= sw[3:0];
              r_cnt   <= '0;
              r_issue <= 1'b1;
            end
          end
          S_WAIT: begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= res_in;
              r_flags  <= flags_in;
              r_cap    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign sel       = r_sel;
  assign issue     = r_issue;
  assign busy      = (r_state == S_WAIT);
  assign result    = r_result;
  assign flags     = r_flags;
  assign done      = r_done;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer (N=5, LAT=2): table of full operations plus
// hand-written hold, clear-vs-press and mid-wait reset sequences.
module tb_alu_operand_sequencer;

  localparam int unsigned N   = 5;
  localparam int unsigned LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] sw = '0;
  logic         btn = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] A, B, result;
  logic [3:0]   sel, flags;
  logic         issue, busy, done;
  logic [N-1:0] res_in = '0;
  logic [3:0]   flags_in = '0;
  logic [2:0]   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  alu_operand_sequencer #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .clr(clr),
    .A(A), .B(B), .sel(sel), .issue(issue), .busy(busy),
    .res_in(res_in), .flags_in(flags_in),
    .result(result), .flags(flags), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [N-1:0] sw_a;
    logic [N-1:0] sw_b;
    logic [N-1:0] sw_op;
    logic [N-1:0] alu_res;
    logic [3:0]   alu_flg;
    bit           glitch;   // re-press the button so a press lands inside the wait state
    logic [3:0]   exp_sel;
  } op_t;

  op_t ops[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench just after the edge on which the press takes effect.
  task automatic do_press(input logic [N-1:0] v, input bit glitch);
    sw  = v;
    btn = 1'b1;
    tick();
    if (glitch) btn = 1'b0;
    tick();
    btn = 1'b1;
    tick();
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_op(input op_t o);
    int n;
    int issues;
    int dones;
    bit stable;
    chk("op_start_state", state_dbg, 0);
    do_press(o.sw_a, 1'b0);
    chk("capture_a", A, o.sw_a);
    chk("state_b", state_dbg, 1);
    release_btn();
    do_press(o.sw_b, 1'b0);
    chk("capture_b", B, o.sw_b);
    chk("state_op", state_dbg, 2);
    release_btn();
    do_press(o.sw_op, o.glitch);
    chk("state_wait", state_dbg, 3);
    chk("issue_pulse", issue, 1);
    chk("busy_wait", busy, 1);
    chk("capture_sel", sel, o.exp_sel);
    res_in   = o.alu_res;
    flags_in = o.alu_flg;
    if (!o.glitch) btn = 1'b0;
    n = 0; issues = 1; stable = 1'b1;
    while (n < 10 && done !== 1'b1) begin
      tick();
      n++;
      if (issue === 1'b1) issues++;
      if (state_dbg == 3'd3 && (A !== o.sw_a || B !== o.sw_b || sel !== o.exp_sel)) stable = 1'b0;
    end
    chk("issue_to_done", n, LAT + 1);
    chk("issue_count", issues, 1);
    chk("operands_stable", stable, 1);
    chk("result", result, o.alu_res);
    chk("flags", flags, o.alu_flg);
    chk("state_show", state_dbg, 4);
    chk("busy_show", busy, 0);
    res_in = '0;
    flags_in = '0;
    dones = 0;
    repeat (3) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("single_done", dones, 0);
    chk("show_holds", state_dbg, 4);
    chk("result_held", result, o.alu_res);
    release_btn();
    do_press('0, 1'b0);
    chk("show_to_a", state_dbg, 0);
    chk("a_kept", A, o.sw_a);
    release_btn();
  endtask

  initial begin
    ops[0] = '{sw_a: 5'd7,  sw_b: 5'd3,  sw_op: 5'h02, alu_res: 5'd10,
               alu_flg: 4'b0000, glitch: 1'b0, exp_sel: 4'h2};
    ops[1] = '{sw_a: 5'd31, sw_b: 5'd1,  sw_op: 5'h1a, alu_res: 5'd0,
               alu_flg: 4'b1010, glitch: 1'b1, exp_sel: 4'ha};
    ops[2] = '{sw_a: 5'd5,  sw_b: 5'd12, sw_op: 5'h05, alu_res: 5'd17,
               alu_flg: 4'b0001, glitch: 1'b0, exp_sel: 4'h5};

    repeat (3) tick();
    chk("reset_outputs", {A, B, sel, result, flags, issue, done, busy, state_dbg}, '0);
    rst = 1'b1;
    tick();
    chk("post_release_state", state_dbg, 0);

    for (int i = 0; i < 3; i++) run_op(ops[i]);

    // Held button: one advance only.
    sw  = 5'd5;
    btn = 1'b1;
    repeat (20) tick();
    chk("hold_state", state_dbg, 1);
    chk("hold_a", A, 5);
    chk("hold_b_unchanged", B, 12);
    release_btn();

    // clr wins over a press landing on the same edge in S_B.
    sw  = 5'd9;
    btn = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_state", state_dbg, 0);
    chk("clr_ab", {A, B, sel}, 0);
    chk("clr_result_kept", result, 17);
    chk("clr_flags_kept", flags, 4'b0001);
    release_btn();
    chk("clr_stays_a", state_dbg, 0);

    // Asynchronous reset in the middle of S_WAIT.
    do_press(5'd7, 1'b0); release_btn();
    do_press(5'd3, 1'b0); release_btn();
    do_press(5'd2, 1'b0);
    btn = 1'b0;
    res_in = 5'd10;
    chk("pre_reset_wait", state_dbg, 3);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_all", {A, B, sel, result, flags, issue, done, busy, state_dbg}, '0);
    repeat (4) tick();
    chk("reset_no_done", done, 0);
    rst = 1'b1;
    res_in = '0;
    tick();
    chk("reset_release_state", state_dbg, 0);
    chk("reset_release_result", result, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
